// File: rtl/register_file_mp.sv
// Multi-port integer register file with write-port priority and a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2,
   parameter int ZERO_REG   = 1,
   localparam int ADDR_W    = $clog2(NUM_REGS),
   localparam int CNT_W     = ADDR_W + 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_READ*ADDR_W-1:0]       read_id,
   output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
   output logic [NUM_READ-1:0]              read_busy,
   input  logic [NUM_WRITE-1:0]             write_en,
   input  logic [NUM_WRITE*ADDR_W-1:0]      write_id,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]  write_data,
   input  logic                             reserve_en,
   input  logic [ADDR_W-1:0]                reserve_id,
   output logic [CNT_W-1:0]                 busy_count
);

   logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
   logic [DATA_WIDTH-1:0] wr_val [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_hit;
   logic [NUM_REGS-1:0]   busy_q;
   logic [NUM_REGS-1:0]   busy_next;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [CNT_W-1:0] sum;
      sum = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         sum = sum + CNT_W'(v[i]);
      end
      return sum;
   endfunction

   // Per-register write decode; later ports overwrite earlier ones so the highest port wins.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_hit[i] = 1'b0;
         wr_val[i] = '0;
         for (int p = 0; p < NUM_WRITE; p++) begin
            if (write_en[p] && (write_id[p*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
               wr_hit[i] = 1'b1;
               wr_val[i] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
      if (ZERO_REG != 0) begin
         wr_hit[0] = 1'b0;
      end
   end

   // Completing writes clear busy first; a same-cycle reserve re-marks it for the new producer.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_next[i] = busy_q[i];
         for (int p = 0; p < NUM_WRITE; p++) begin
            if (write_en[p] && (write_id[p*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
               busy_next[i] = 1'b0;
            end
         end
         if (reserve_en && (reserve_id == ADDR_W'(i))) begin
            busy_next[i] = 1'b1;
         end
      end
      if (ZERO_REG != 0) begin
         busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         busy_count <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         busy_q     <= busy_next;
         busy_count <= popcount(busy_next);
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i]) begin
               regs[i] <= wr_val[i];
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
      logic [ADDR_W-1:0]     rd_addr;
      logic [DATA_WIDTH-1:0] rd_val;
      logic                  rd_bsy;

      always_comb begin
         rd_addr = read_id[r*ADDR_W +: ADDR_W];
         rd_val  = regs[rd_addr];
         rd_bsy  = busy_q[rd_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
         // Forward pending write data; held off during reset so reads stay zero.
         for (int p = 0; p < NUM_WRITE; p++) begin
            if (!reset && write_en[p] && (write_id[p*ADDR_W +: ADDR_W] == rd_addr)) begin
               rd_val = write_data[p*DATA_WIDTH +: DATA_WIDTH];
               rd_bsy = 1'b0;
            end
         end
`endif
         if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_val = '0;
            rd_bsy = 1'b0;
         end
         read_data[r*DATA_WIDTH +: DATA_WIDTH] = rd_val;
         read_busy[r]                          = rd_bsy;
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed test of register_file_mp: default configuration plus a wide 4-read/3-write instance.
module tb_register_file_mp;

`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // default instance: 32x32, 2 read, 2 write, x0 hardwired
   logic [9:0]  read_id;
   logic [63:0] read_data;
   logic [1:0]  read_busy;
   logic [1:0]  write_en;
   logic [9:0]  write_id;
   logic [63:0] write_data;
   logic        reserve_en;
   logic [4:0]  reserve_id;
   logic [5:0]  busy_count;

   // wide instance: 16x64, 4 read, 3 write, x0 is an ordinary register
   logic [15:0]  s_read_id;
   logic [255:0] s_read_data;
   logic [3:0]   s_read_busy;
   logic [2:0]   s_write_en;
   logic [11:0]  s_write_id;
   logic [191:0] s_write_data;
   logic         s_reserve_en;
   logic [3:0]   s_reserve_id;
   logic [4:0]   s_busy_count;

   int vecs = 0;
   int errs = 0;

   register_file_mp #(
      .DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(1)
   ) u0 (
      .clk(clk), .reset(reset),
      .read_id(read_id), .read_data(read_data), .read_busy(read_busy),
      .write_en(write_en), .write_id(write_id), .write_data(write_data),
      .reserve_en(reserve_en), .reserve_id(reserve_id), .busy_count(busy_count)
   );

   register_file_mp #(
      .DATA_WIDTH(64), .NUM_REGS(16), .NUM_READ(4), .NUM_WRITE(3), .ZERO_REG(0)
   ) u1 (
      .clk(clk), .reset(reset),
      .read_id(s_read_id), .read_data(s_read_data), .read_busy(s_read_busy),
      .write_en(s_write_en), .write_id(s_write_id), .write_data(s_write_data),
      .reserve_en(s_reserve_en), .reserve_id(s_reserve_id), .busy_count(s_busy_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input logic [4:0] id, input logic [31:0] d);
      write_en[p]          = 1'b1;
      write_id[p*5 +: 5]   = id;
      write_data[p*32 +: 32] = d;
   endtask

   task automatic rd(input int p, input logic [4:0] id);
      read_id[p*5 +: 5] = id;
   endtask

   task automatic swr(input int p, input logic [3:0] id, input logic [63:0] d);
      s_write_en[p]            = 1'b1;
      s_write_id[p*4 +: 4]     = id;
      s_write_data[p*64 +: 64] = d;
   endtask

   task automatic idle();
      write_en     = '0;
      reserve_en   = 1'b0;
      s_write_en   = '0;
      s_reserve_en = 1'b0;
   endtask

   initial begin
      read_id = '0; write_en = '0; write_id = '0; write_data = '0;
      reserve_en = 1'b0; reserve_id = '0;
      s_read_id = '0; s_write_en = '0; s_write_id = '0; s_write_data = '0;
      s_reserve_en = 1'b0; s_reserve_id = '0;

      // asynchronous power-on reset, no clock edge needed
      #1 reset = 1'b1;
      #2;
      rd(0, 5'd5); rd(1, 5'd0);
      #1;
      check("rst_rd0", read_data[31:0], 64'h0);
      check("rst_rd1", read_data[63:32], 64'h0);
      check("rst_busy", read_busy, 64'h0);
      check("rst_cnt", busy_count, 64'h0);
      check("rst_scnt", s_busy_count, 64'h0);
      tick();
      reset = 1'b0;

      // basic write, read one cycle later on port 1
      wr(0, 5'd3, 32'h12345678); rd(1, 5'd3);
      #1;
      check("wr_same_cycle", read_data[63:32], BYP ? 64'h12345678 : 64'h0);
      tick(); idle();
      #1;
      check("wr_x3", read_data[63:32], 64'h12345678);

      // writes to x0 are discarded
      wr(0, 5'd0, 32'hFFFFFFFF); wr(1, 5'd0, 32'hFFFFFFFF);
      rd(0, 5'd0); rd(1, 5'd0);
      #1;
      check("x0_bypass_rd", read_data[31:0], 64'h0);
      tick(); idle();
      #1;
      check("x0_rd0", read_data[31:0], 64'h0);
      check("x0_rd1", read_data[63:32], 64'h0);

      // same-address collision: port 1 wins
      wr(0, 5'd7, 32'h0000AAAA); wr(1, 5'd7, 32'h00005555);
      tick(); idle();
      rd(0, 5'd7);
      #1;
      check("collide_x7", read_data[31:0], 64'h5555);

      // scoreboard: reserve, complete, reserve+complete together
      reserve_en = 1'b1; reserve_id = 5'd9;
      tick(); idle();
      rd(0, 5'd9);
      #1;
      check("rsv_busy", read_busy[0], 64'h1);
      check("rsv_cnt", busy_count, 64'h1);
      wr(1, 5'd9, 32'h42);
      tick(); idle();
      #1;
      check("cmp_busy", read_busy[0], 64'h0);
      check("cmp_cnt", busy_count, 64'h0);
      check("cmp_data", read_data[31:0], 64'h42);
      wr(0, 5'd9, 32'h42); reserve_en = 1'b1; reserve_id = 5'd9;
      tick(); idle();
      #1;
      check("rsvwr_busy", read_busy[0], 64'h1);
      check("rsvwr_cnt", busy_count, 64'h1);
      check("rsvwr_data", read_data[31:0], 64'h42);
      reserve_en = 1'b1; reserve_id = 5'd0; rd(1, 5'd0);
      tick(); idle();
      #1;
      check("rsv_x0_busy", read_busy[1], 64'h0);
      check("rsv_x0_cnt", busy_count, 64'h1);

      // forwarding window: x4 was never written, x9 is busy holding 0x42
      wr(0, 5'd4, 32'h99); rd(0, 5'd4);
      wr(1, 5'd9, 32'h77); rd(1, 5'd9);
      #1;
      check("byp_x4_data", read_data[31:0], BYP ? 64'h99 : 64'h0);
      check("byp_x9_data", read_data[63:32], BYP ? 64'h77 : 64'h42);
      check("byp_x9_busy", read_busy[1], BYP ? 64'h0 : 64'h1);
      tick(); idle();
      #1;
      check("post_x4", read_data[31:0], 64'h99);
      check("post_x9", read_data[63:32], 64'h77);
      check("post_x9_busy", read_busy[1], 64'h0);
      check("post_cnt", busy_count, 64'h0);

      // wide instance: three ports write distinct registers while x0 is reserved
      swr(0, 4'd0, 64'h0123456789ABCDEF);
      swr(1, 4'd1, 64'hFEDCBA9876543210);
      swr(2, 4'd15, 64'hA5A5A5A5_5A5A5A5A);
      s_reserve_en = 1'b1; s_reserve_id = 4'd0;
      tick(); idle();
      swr(0, 4'd2, 64'h1); swr(1, 4'd2, 64'h2); swr(2, 4'd2, 64'h3);
      tick(); idle();
      s_read_id = {4'd2, 4'd15, 4'd1, 4'd0};
      #1;
      check("s_rd0_x0", s_read_data[63:0], 64'h0123456789ABCDEF);
      check("s_rd1_x1", s_read_data[127:64], 64'hFEDCBA9876543210);
      check("s_rd2_x15", s_read_data[191:128], 64'hA5A5A5A55A5A5A5A);
      check("s_rd3_x2", s_read_data[255:192], 64'h3);
      check("s_busy", s_read_busy, 64'h1);
      check("s_cnt", s_busy_count, 64'h1);

      // mid-cycle asynchronous reset after x5 written and reserved
      wr(0, 5'd5, 32'hDEADBEEF); reserve_en = 1'b1; reserve_id = 5'd5;
      tick(); idle();
      rd(0, 5'd5);
      #1;
      check("pre_rst_x5", read_data[31:0], 64'hDEADBEEF);
      check("pre_rst_cnt", busy_count, 64'h1);
      #1 reset = 1'b1;
      #1;
      check("async_x5", read_data[31:0], 64'h0);
      check("async_busy", read_busy[0], 64'h0);
      check("async_cnt", busy_count, 64'h0);
      check("async_s_x0", s_read_data[63:0], 64'h0);
      wr(0, 5'd6, 32'h1234); reserve_en = 1'b1; reserve_id = 5'd6; rd(1, 5'd6);
      #1;
      check("rst_no_byp", read_data[63:32], 64'h0);
      tick();
      reset = 1'b0; idle();
      #1;
      check("rst_drop_x6", read_data[63:32], 64'h0);
      check("rst_drop_cnt", busy_count, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no end, expected finish before 20000");
      $fatal(1, "timeout");
   end

endmodule
